// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and the load/store alignment logic.
package dmem_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE,
        DMEM_WAIT,
        DMEM_RESP
    } dmem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int WAIT_CNT_BITS = 4;

    // Stores only have signed encodings; loads add the two unsigned ones.
    function automatic logic funct3_legal(input logic write, input logic [2:0] func_3);
        if (write)
            return (func_3 == F3_B) || (func_3 == F3_H) || (func_3 == F3_W);
        return (func_3 == F3_B) || (func_3 == F3_H) || (func_3 == F3_W) ||
               (func_3 == F3_BU) || (func_3 == F3_HU);
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational RISC-V byte/half/word lane selection: load extraction and extension,
// store merge with byte enables, and misalignment detection.
module load_store_align
    import dmem_pkg::*;
(
    input  logic [1:0]  address_low,
    input  logic [2:0]  func_3,
    input  logic [31:0] word_in,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] store_word,
    output logic [3:0]  byte_enable,
    output logic        misaligned
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    assign byte_val = word_in[{address_low, 3'b000} +: 8];
    assign half_val = address_low[1] ? word_in[31:16] : word_in[15:0];

    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        load_data   = '0;
        store_word  = word_in;
        byte_enable = '0;
        misaligned  = 1'b0;
        case (func_3)
            F3_B: begin
                load_data   = {{24{byte_val[7]}}, byte_val};
                byte_enable = 4'b0001 << address_low;
                store_word[{address_low, 3'b000} +: 8] = store_data[7:0];
            end
            F3_H: begin
                load_data   = {{16{half_val[15]}}, half_val};
                byte_enable = address_low[1] ? 4'b1100 : 4'b0011;
                if (address_low[1])
                    store_word[31:16] = store_data[15:0];
                else
                    store_word[15:0] = store_data[15:0];
                misaligned  = address_low[0];
            end
            F3_W: begin
                load_data   = word_in;
                byte_enable = 4'b1111;
                store_word  = store_data;
                misaligned  = |address_low;
            end
            F3_BU: load_data = {24'h0, byte_val};
            F3_HU: begin
                load_data  = {16'h0, half_val};
                misaligned = address_low[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_memory_responder.sv
// Valid/ready data-memory responder with programmable wait states.
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses.
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int    data_bits           = 32,
    parameter int    memory_size         = 1024,
    parameter int    memory_address_bits = $clog2(memory_size),
    parameter int    wait_states         = 1,
    parameter string input_file          = ""
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [31:0]          req_address,
    input  logic [2:0]           req_func_3_bits,
    input  logic [data_bits-1:0] req_write_data,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [data_bits-1:0] resp_read_data,
    output logic                 resp_error
);

    localparam logic [32:0] byte_limit = 33'(memory_size) << 2;

    logic [31:0] mem [memory_size];

    dmem_state_t              state, state_next;
    logic [WAIT_CNT_BITS-1:0] count, count_next;
    logic                     accept, execute;

    logic        lat_write;
    logic [31:0] lat_address;
    logic [2:0]  lat_func_3;
    logic [31:0] lat_write_data;

    // The access executes either straight out of IDLE (no wait states) or from the latched request.
    logic        acc_write;
    logic [31:0] acc_address;
    logic [2:0]  acc_func_3;
    logic [31:0] acc_write_data;
    logic        acc_error;
    logic [memory_address_bits-1:0] word_index;

    logic [31:0] load_data, store_word;
    logic [3:0]  byte_enable;
    logic        misaligned;

    assign acc_write      = (state == DMEM_IDLE) ? req_write       : lat_write;
    assign acc_address    = (state == DMEM_IDLE) ? req_address     : lat_address;
    assign acc_func_3     = (state == DMEM_IDLE) ? req_func_3_bits : lat_func_3;
    assign acc_write_data = (state == DMEM_IDLE) ? req_write_data  : lat_write_data;
    assign word_index     = acc_address[memory_address_bits+1:2];

    load_store_align u_align (
        .address_low (acc_address[1:0]),
        .func_3      (acc_func_3),
        .word_in     (mem[word_index]),
        .store_data  (acc_write_data),
        .load_data   (load_data),
        .store_word  (store_word),
        .byte_enable (byte_enable),
        .misaligned  (misaligned)
    );

`ifdef DMEM_MISALIGN_TRAP_EN
    assign acc_error = ({1'b0, acc_address} >= byte_limit) ||
                       !funct3_legal(acc_write, acc_func_3) || misaligned;
`else
    logic unused_misaligned;
    assign unused_misaligned = misaligned;
    assign acc_error = ({1'b0, acc_address} >= byte_limit) ||
                       !funct3_legal(acc_write, acc_func_3);
`endif

    always_comb begin
        state_next = state;
        count_next = count;
        accept     = 1'b0;
        execute    = 1'b0;
        case (state)
            DMEM_IDLE: begin
                if (req_valid && req_ready) begin
                    accept = 1'b1;
                    if (wait_states == 0) begin
                        execute    = 1'b1;
                        state_next = DMEM_RESP;
                    end else begin
                        count_next = WAIT_CNT_BITS'(wait_states - 1);
                        state_next = DMEM_WAIT;
                    end
                end
            end
            DMEM_WAIT: begin
                if (count == '0) begin
                    execute    = 1'b1;
                    state_next = DMEM_RESP;
                end else begin
                    count_next = count - 1'b1;
                end
            end
            DMEM_RESP: begin
                if (resp_valid && resp_ready)
                    state_next = DMEM_IDLE;
            end
            default: state_next = DMEM_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= DMEM_IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_read_data <= '0;
            resp_error     <= 1'b0;
        end else begin
            if (accept)
                req_ready <= 1'b0;
            if (execute) begin
                resp_error     <= acc_error;
                resp_read_data <= (acc_error || acc_write) ? '0 : load_data;
            end
            // Response is presented one cycle after the execution edge.
            if (state == DMEM_RESP && !resp_valid) begin
                resp_valid <= 1'b1;
            end else if (resp_valid && resp_ready) begin
                resp_valid <= 1'b0;
                req_ready  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_write      <= req_write;
            lat_address    <= req_address;
            lat_func_3     <= req_func_3_bits;
            lat_write_data <= req_write_data;
        end
    end

    // NOTE: the array is deliberately not reset; only a store that reaches its execution edge writes.
    always_ff @(posedge clk) begin
        if (!reset && execute && acc_write && !acc_error) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_enable[i])
                    mem[word_index][8*i +: 8] <= store_word[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench: the driver queues expected responses, a monitor checks them as they appear.
module tb_data_memory_responder;
    import dmem_pkg::*;

    localparam int WS  = 2;
    localparam int MSZ = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_address = '0;
    logic [2:0]  req_func_3_bits = '0;
    logic [31:0] req_write_data = '0;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_read_data;
    logic        resp_error;

    data_memory_responder #(
        .data_bits   (32),
        .memory_size (MSZ),
        .wait_states (WS)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_address     (req_address),
        .req_func_3_bits (req_func_3_bits),
        .req_write_data  (req_write_data),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_read_data  (resp_read_data),
        .resp_error      (resp_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          accept_edge;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   hs_edge = -1;
    int   stall_left = 0;
    int   passed = 0;
    int   total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        total++;
        if (actual === required)
            passed++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, actual, required, cyc);
    endtask

    task automatic send(input logic wr, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] wd, input logic [31:0] exp_data, input logic exp_err);
        int waited = 0;
        int accept_edge;
        @(negedge clk);
        req_valid       = 1'b1;
        req_write       = wr;
        req_address     = addr;
        req_func_3_bits = f3;
        req_write_data  = wd;
        while (!req_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            check("req_accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        accept_edge = cyc + 1;
        check("accept_after_resp", 32'(accept_edge > hs_edge), 32'd1);
        exp_q.push_back('{exp_data, exp_err, accept_edge});
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int waited = 0;
        while ((exp_q.size() != 0 || resp_valid || !req_ready) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200)
            check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: acts as the response-side initiator and compares against the queue.
    initial begin : monitor
        logic in_resp = 1'b0;
        exp_t cur;
        resp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_resp    = 1'b0;
                resp_ready = 1'b0;
            end else if (resp_valid) begin
                if (!in_resp) begin
                    in_resp = 1'b1;
                    if (exp_q.size() == 0) begin
                        check("unexpected_resp", 32'd1, 32'd0);
                        cur = '{resp_read_data, resp_error, cyc};
                    end else begin
                        cur = exp_q.pop_front();
                        check("resp_data", resp_read_data, cur.data);
                        check("resp_error", 32'(resp_error), 32'(cur.err));
                        check("resp_latency", 32'(cyc - cur.accept_edge), 32'(1 + WS));
                    end
                end else begin
                    check("hold_data", resp_read_data, cur.data);
                    check("hold_req_ready_low", 32'(req_ready), 32'd0);
                end
                if (stall_left > 0) begin
                    stall_left--;
                    resp_ready = 1'b0;
                end else begin
                    resp_ready = 1'b1;
                    hs_edge    = cyc + 1;
                end
            end else begin
                in_resp    = 1'b0;
                resp_ready = 1'b0;
            end
        end
    end

    initial begin : driver
        int waited;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_resp_data", resp_read_data, 32'd0);
        check("reset_resp_error", 32'(resp_error), 32'd0);

        send(1'b1, 32'h10, F3_W, 32'hDEADBEEF, 32'h0, 1'b0);
        send(1'b0, 32'h10, F3_W, 32'h0,        32'hDEADBEEF, 1'b0);

        send(1'b1, 32'h10, F3_W, 32'h00000000, 32'h0, 1'b0);
        send(1'b1, 32'h11, F3_B, 32'h0000007F, 32'h0, 1'b0);
        send(1'b0, 32'h10, F3_W, 32'h0,        32'h00007F00, 1'b0);

        send(1'b1, 32'h10, F3_W,  32'h80000000, 32'h0, 1'b0);
        send(1'b0, 32'h13, F3_B,  32'h0,        32'hFFFFFF80, 1'b0);
        send(1'b0, 32'h13, F3_BU, 32'h0,        32'h00000080, 1'b0);

        send(1'b1, 32'h10, F3_W,  32'h80011234, 32'h0, 1'b0);
        send(1'b0, 32'h12, F3_H,  32'h0,        32'hFFFF8001, 1'b0);
        send(1'b0, 32'h12, F3_HU, 32'h0,        32'h00008001, 1'b0);
        send(1'b0, 32'h10, F3_H,  32'h0,        32'h00001234, 1'b0);

        // Backpressure: response held for 5 cycles, next request waits behind it.
        wait_idle();
        stall_left = 5;
        send(1'b0, 32'h10, F3_W, 32'h0, 32'h80011234, 1'b0);
        send(1'b0, 32'h13, F3_BU, 32'h0, 32'h00000080, 1'b0);

        // Address boundary and illegal encodings.
        send(1'b1, 32'h0000_0FFC, F3_W, 32'h12345678, 32'h0, 1'b0);
        send(1'b0, 32'h0000_0FFC, F3_W, 32'h0, 32'h12345678, 1'b0);
        send(1'b0, 32'(4 * MSZ), F3_W, 32'h0, 32'h0, 1'b1);
        send(1'b1, 32'(4 * MSZ), F3_W, 32'h55555555, 32'h0, 1'b1);
        send(1'b0, 32'h10, 3'b011, 32'h0, 32'h0, 1'b1);
        send(1'b1, 32'h10, F3_BU, 32'hFFFFFFFF, 32'h0, 1'b1);
        send(1'b0, 32'h10, F3_W, 32'h0, 32'h80011234, 1'b0);

`ifdef DMEM_MISALIGN_TRAP_EN
        send(1'b1, 32'h12, F3_W, 32'hCAFEF00D, 32'h0, 1'b1);
        send(1'b0, 32'h10, F3_W, 32'h0, 32'h80011234, 1'b0);
        send(1'b0, 32'h11, F3_H, 32'h0, 32'h0, 1'b1);
`else
        send(1'b1, 32'h12, F3_W, 32'hCAFEF00D, 32'h0, 1'b0);
        send(1'b0, 32'h10, F3_W, 32'h0, 32'hCAFEF00D, 1'b0);
        send(1'b0, 32'h11, F3_H, 32'h0, 32'hFFFFF00D, 1'b0);
`endif

        // Reset while a store sits in WAIT: store must be dropped.
        send(1'b1, 32'h20, F3_W, 32'h11223344, 32'h0, 1'b0);
        wait_idle();
        @(negedge clk);
        req_valid       = 1'b1;
        req_write       = 1'b1;
        req_address     = 32'h20;
        req_func_3_bits = F3_W;
        req_write_data  = 32'hAAAAAAAA;
        waited = 0;
        while (!req_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("mid_wait_state", 32'(dut.state), 32'(DMEM_WAIT));
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post_reset_state", 32'(dut.state), 32'(DMEM_IDLE));
        check("post_reset_resp_valid", 32'(resp_valid), 32'd0);
        check("post_reset_req_ready", 32'(req_ready), 32'd1);
        send(1'b0, 32'h20, F3_W, 32'h0, 32'h11223344, 1'b0);

        wait_idle();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
